// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per cycle, start/done handshake.
// Optional sticky overflow flag enabled by defining BIN_TO_BCD_OVF_EN; otherwise ovf is tied low.
module bin_to_bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, CONV} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]   work_q, work_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic            done_q, done_d;
   logic [BW-1:0]   adj;
   logic [BW-1:0]   work_nxt;
   logic            carry_out;
   logic            accept;
   logic            finish;

   assign accept = (state_q == IDLE) && start;
   assign finish = (state_q == CONV) && (cnt_q == CW'(1));

   // Digits are adjusted independently; the top bit of the adjusted register falls out on the shift.
   always_comb begin
      adj = work_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (work_q[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
         end
      end
      {carry_out, work_nxt} = {adj, shift_q[WIDTH-1]};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      work_d  = work_q;
      bcd_d   = bcd_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               shift_d = bin;
               work_d  = '0;
               cnt_d   = CW'(WIDTH);
               state_d = CONV;
            end
         end
         CONV: begin
            work_d  = work_nxt;
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               bcd_d   = work_nxt;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         work_q  <= '0;
         bcd_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         work_q  <= work_d;
         bcd_q   <= bcd_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == CONV);
   assign done = done_q;
   assign bcd  = bcd_q;

`ifdef BIN_TO_BCD_OVF_EN
   logic sticky_q, sticky_d;
   logic ovf_q, ovf_d;

   always_comb begin
      sticky_d = sticky_q;
      ovf_d    = ovf_q;
      if (accept) begin
         sticky_d = 1'b0;
      end else if (state_q == CONV) begin
         sticky_d = sticky_q | carry_out;
      end
      // Include this iteration's carry so the final shift is not missed.
      if (finish) begin
         ovf_d = sticky_q | carry_out;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
         ovf_q    <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   logic carry_unused;
   logic accept_unused;
   logic finish_unused;
   assign carry_unused  = carry_out;
   assign accept_unused = accept;
   assign finish_unused = finish;
   assign ovf           = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed conversions on a 3-digit and a 2-digit instance,
// expected results queued at issue and checked by per-instance monitors on done.
module tb_bin_to_bcd_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        start, start2;
   logic [7:0]  bin, bin2;
   logic        busy, done, ovf;
   logic [11:0] bcd;
   logic        busy2, done2, ovf2;
   logic [7:0]  bcd2;

   int checks   = 0;
   int failures = 0;

   logic [12:0] exp_q[$];
   logic [8:0]  exp2_q[$];
   logic        prev_done, prev_done2;

`ifdef BIN_TO_BCD_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
      .clk(clk), .rst(rst), .start(start), .bin(bin),
      .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
   );

   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .bin(bin2),
      .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [11:0] dec3(input int v);
      return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Monitors: pop the expected result whenever a done pulse is presented.
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            chk("done_not_consecutive", {31'd0, prev_done}, 32'd0);
            for (int k = 0; k < 3; k++) chk("digit_le_9", {31'd0, bcd[4*k +: 4] > 4'd9}, 32'd0);
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               logic [12:0] e;
               e = exp_q.pop_front();
               chk("bcd", {20'd0, bcd}, {20'd0, e[11:0]});
               chk("ovf", {31'd0, ovf}, {31'd0, e[12]});
            end
         end
         if (done2) begin
            chk("done2_not_consecutive", {31'd0, prev_done2}, 32'd0);
            if (exp2_q.size() == 0) begin
               chk("unexpected_done2", 32'd1, 32'd0);
            end else begin
               logic [8:0] e2;
               e2 = exp2_q.pop_front();
               chk("bcd2", {24'd0, bcd2}, {24'd0, e2[7:0]});
               chk("ovf2", {31'd0, ovf2}, {31'd0, e2[8]});
            end
         end
      end
      prev_done  <= done;
      prev_done2 <= done2;
   end

   // Issue one conversion and follow it to its done cycle; returns in the done cycle.
   task automatic convert(input logic [7:0] v, input logic [11:0] exp_bcd, input bit hold);
      int  n;
      bit  seen;
      bin   = v;
      start = 1'b1;
      exp_q.push_back({1'b0, exp_bcd});
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (!hold) start = 1'b0;
         bin = ~v;
         if (done) seen = 1'b1;
         else chk("busy_during_conv", {31'd0, busy}, 32'd1);
      end
      start = 1'b0;
      chk("done_latency", n, 32'd9);
      chk("busy_low_in_done", {31'd0, busy}, 32'd0);
   endtask

   task automatic convert2(input logic [7:0] v, input logic [7:0] exp_bcd, input bit exp_ovf);
      int n;
      bin2   = v;
      start2 = 1'b1;
      exp2_q.push_back({exp_ovf, exp_bcd});
      @(posedge clk); #1;
      start2 = 1'b0;
      n = 1;
      while (!done2 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done2_latency", n, 32'd9);
   endtask

   initial begin
      int n;
      rst    = 1'b1;
      start  = 1'b0;
      start2 = 1'b0;
      bin    = 8'd0;
      bin2   = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_bcd",  {20'd0, bcd},  32'd0);
      chk("rst_ovf",  {31'd0, ovf},  32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      convert(8'd255, 12'h255, 1'b0);
      @(posedge clk); #1;
      convert(8'd0, 12'h000, 1'b0);
      @(posedge clk); #1;
      convert(8'd99, 12'h099, 1'b1);
      repeat (2) begin
         @(posedge clk); #1;
         chk("held_start_single_conv", {31'd0, busy | done}, 32'd0);
      end

      convert(8'd128, 12'h128, 1'b0);
      convert(8'd7, 12'h007, 1'b0);
      @(posedge clk); #1;

      // Abort a conversion with reset; no done may follow.
      bin   = 8'd200;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_bcd",  {20'd0, bcd},  32'd0);
      chk("abort_ovf",  {31'd0, ovf},  32'd0);
      n = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) n++;
      end
      chk("abort_no_done", n, 32'd0);
      convert(8'd42, 12'h042, 1'b0);
      @(posedge clk); #1;

      for (int v = 0; v < 256; v++) convert(8'(v), dec3(v), 1'b0);
      @(posedge clk); #1;

      convert2(8'd123, 8'h23, OVF_ON);
      @(posedge clk); #1;
      convert2(8'd99, 8'h99, 1'b0);
      @(posedge clk); #1;
      convert2(8'd200, 8'h00, OVF_ON);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 32'd0);
      chk("queue2_drained", exp2_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3) that produces the packed BCD digits consumed by the `bcd` seven-segment decoders. It sits between a binary datapath source (counter, switches, ALU result) and one `bcd` decoder per digit. It converts one WIDTH-bit unsigned value per request using a start/done handshake, taking WIDTH cycles per conversion.

## Interface
- WIDTH, 8, bit width of unsigned binary input (≥1)
- DIGITS, 3, number of BCD output digits (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  conversion request, sampled only in IDLE
- bin  input  WIDTH  binary value, captured on accepted start
- busy  output  1  high while converting
- done  output  1  one-cycle pulse: bcd/ovf just updated
- bcd  output  4*DIGITS  packed result, digit 0 (ones) in [3:0], digit k in [4k+3:4k]
- ovf  output  1  result did not fit in DIGITS digits (see Configuration)

## Operation
- FSM states: IDLE, CONV. Reset → IDLE.
- Reset values: busy=0, done=0, bcd=0, ovf=0, iteration counter=0, working registers=0.
- IDLE with start=1: capture bin into shift register, clear working BCD register and sticky overflow, load counter=WIDTH, go to CONV. IDLE with start=0: hold.
- CONV, each cycle, one iteration:
  - Every working digit ≥5 gets +3 (4-bit add, no carry between digits).
  - Then shift the {BCD, bin} concatenation left by 1; the bin MSB enters BCD bit 0, and the BCD top bit is shifted out.
  - Shifted-out bit =1 sets the sticky overflow.
  - Counter decrements.
- On the iteration where the counter goes 1→0:
  - Register the post-shift working value into bcd.
  - Register the sticky flag into ovf.
  - Pulse done=1 for the next cycle.
  - Return to IDLE.
- start during CONV is ignored; bin changes during CONV have no effect.
- bcd/ovf hold their last completed values until the next completion; they never show intermediate values.
- Arithmetic: result digits equal the bin value mod 10^DIGITS; every digit is always 0–9.

## Timing
- Start accepted at edge E0 (IDLE, start=1). busy=1 in cycles after E0 … E(WIDTH−1); done=1 and new bcd visible after E(WIDTH); busy=0 in that same cycle.
- Latency: WIDTH+1 clocks from start sample to done. With the defaults, done asserts 9 cycles after start.
- done coincides with IDLE, so a start in the done cycle is accepted: back-to-back throughput is one conversion per WIDTH+1 cycles.
- done never asserts for two consecutive cycles.
- rst mid-conversion: next cycle IDLE, busy=0, done=0, bcd=0, ovf=0, no done pulse for the aborted conversion.
- rst and start in the same cycle: rst wins.

## Configuration
- BIN_TO_BCD_OVF_EN defined: sticky overflow logic present; ovf reports lost significance, updated with bcd on completion. bcd still holds the value mod 10^DIGITS.
- BIN_TO_BCD_OVF_EN undefined: no overflow logic; ovf tied 0; bcd behaviour identical.

## Test plan
- Defaults, reset then bin=8'd255, start 1 cycle → busy high 8 cycles, done pulse 9 cycles after start, bcd=12'h255, ovf=0.
- bin=0 → bcd=12'h000. Then bin=8'd99 with start held high through CONV → single conversion, single done, bcd=12'h099.
- bin=8'd128 then start again in the done cycle with bin=8'd7 → bcd=12'h128, then 9 cycles later bcd=12'h007; no idle gap.
- Start bin=8'd200, assert rst 4 cycles later → busy=0, bcd=0 the next cycle, no done; a fresh start with bin=8'd42 → bcd=12'h042.
- WIDTH=8, DIGITS=2, bin=8'd123 → bcd=8'h23; ovf=1 with BIN_TO_BCD_OVF_EN, ovf=0 without; bin=8'd99 → ovf=0.
- Exhaustive sweep 0–255 with defaults → every bcd matches the decimal value; every digit field ≤9.
